// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise logic unit between two requesters
module logic_unit_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             grant0, grant1;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] result;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        // ptr == 0 means requester 0 wins a tie
        if (req0_valid && (!req1_valid || !ptr)) grant0 = 1'b1;
        else if (req1_valid)                     grant1 = 1'b1;
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_q)
      2'b00: result = a_q & b_q;
      2'b01: result = a_q | b_q;
      2'b10: result = a_q ^ b_q;
      2'b11: result = ~(a_q ^ b_q);
      default: result = '0;
    endcase
  end

  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      resp_data <= '0;
      resp_zero <= 1'b0;
      resp_id   <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        op_q <= grant1 ? req1_op : req0_op;
        a_q  <= grant1 ? req1_a  : req0_a;
        b_q  <= grant1 ? req1_b  : req0_b;
        id_q <= grant1;
        // pointer moves to the requester that was not just served
        ptr  <= grant0;
      end
      if (state == EXEC) begin
        resp_data <= result;
        resp_zero <= (result == '0);
        resp_id   <= id_q;
      end
      if (state == RESP && resp_ready) op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares a single WIDTH-bit bitwise logic unit (AND/OR/XOR/XNOR) between two requesters. It sits in the BinaryLogic stage between the requesting units and the logic datapath. It accepts one operation at a time through valid/ready handshakes and returns a registered result on a shared response channel tagged with the requester ID. It also keeps a running count of completed operations.

## Interface
- WIDTH, 4, operand and result width in bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  requester 0 opcode
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result (0 or 1)
- resp_data  out  WIDTH  result
- resp_zero  out  1  resp_data is all zeros
- busy  out  1  state is not IDLE
- op_count  out  8  completed responses, modulo 256

## Operation
- Opcodes: 00 = a AND b; 01 = a OR b; 10 = a XOR b; 11 = ~(a XOR b). All four codes are defined; there is no illegal opcode.
- State machine:
  - IDLE:
    - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally in the same cycle.
    - On that edge, latch op, a and b, and latch the granted ID.
    - Move to EXEC.
  - EXEC:
    - Compute the result from the latched operands.
    - Register the result into resp_data and resp_zero, and set resp_id to the latched ID.
    - Move to RESP.
  - RESP:
    - Hold resp_valid high. resp_data, resp_id and resp_zero stay stable.
    - On an edge with resp_ready=1: return to IDLE and increment op_count.
- Arbitration:
  - A 1-bit priority pointer names the preferred requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the preferred requester is granted.
  - On every grant, the pointer moves to the other requester.
- reqN_ready is high only in IDLE, only for the granted requester, and only when that requester's valid is high. It is never high for both requesters.
- Requesters hold op, a and b stable while valid is high and ready is low. The block does not check this.
- Operands are latched at grant. Changes on the request inputs after acceptance have no effect on the result.
- op_count wraps from 255 to 0 with no flag.

## Timing
- Reset values:
  - state IDLE, pointer = 0 (requester 0 preferred)
  - resp_valid 0, resp_data 0, resp_id 0, resp_zero 0
  - busy 0, op_count 0
  - req0_ready and req1_ready 0 while rst is high
- Latency:
  - Accept edge E0 (IDLE to EXEC). EXEC occupies the cycle after E0.
  - At E1, resp_valid rises with the result.
  - The response handshake takes at least one cycle.
- Throughput: one operation per 3 cycles when resp_ready is held high (IDLE, EXEC, RESP).
- Backpressure: with resp_ready low in RESP, the block stays in RESP indefinitely. Both ready outputs stay 0, and the pointer and op_count do not change.
- Simultaneous events:
  - A new request arriving during EXEC or RESP waits and is considered in the next IDLE cycle.
  - If a request deasserts valid in IDLE before it is granted, it is not granted and the pointer does not change.
- Reset mid-operation: a synchronous rst in EXEC or RESP abandons the operation. No response completes and op_count does not increment. All outputs take reset values on that edge.
- resp_data and resp_zero hold their last value after returning to IDLE. Only resp_valid drops.

## Test plan
- Single XOR:
  - Stimulus: req0 op=10, a=1101, b=0111; resp_ready=1.
  - Required: req0_ready for 1 cycle; resp_valid exactly 2 edges after acceptance with resp_data=1010, resp_id=0, resp_zero=0; op_count=1.
- Zero flag:
  - Stimulus: req1 op=10, a=1010, b=1010.
  - Required: resp_data=0000, resp_zero=1, resp_id=1.
- All opcodes:
  - Stimulus: a=1100, b=1010 with op 00, 01, 10, 11.
  - Required: results 1000, 1110, 0110, 1001 in order.
- Contention:
  - Stimulus: both requesters valid continuously from reset for 4 operations; resp_ready=1.
  - Required: resp_id sequence 0,1,0,1; each grant 3 cycles apart.
- Backpressure and reset:
  - Stimulus 1: hold resp_ready=0 for 5 cycles in RESP.
  - Required 1: resp_valid and resp_data stable; both ready outputs 0; op_count unchanged.
  - Stimulus 2: assert rst during RESP.
  - Required 2: next cycle resp_valid=0, busy=0, op_count=0, pointer favours req0.
- Wrap-around:
  - Stimulus: 256 completed operations.
  - Required: op_count returns to 0.
